// File: rtl/icache_data_ctrl_pkg.sv
// Shared constants, fill FSM state type and the beat-to-byte-mask helper
// for the instruction-cache data SRAM controller.
package icache_data_ctrl_pkg;

  localparam int SETS       = 16;
  localparam int LINE_W     = 256;
  localparam int BEAT_W     = 64;
  localparam int BEATS      = LINE_W / BEAT_W;
  localparam int ADDR_W     = $clog2(SETS);
  localparam int MASK_W     = LINE_W / 8;
  localparam int BEAT_BYTES = BEAT_W / 8;
  localparam int CNT_W      = $clog2(BEATS);

  typedef enum logic {
    F_IDLE  = 1'b0,
    F_BURST = 1'b1
  } fill_state_e;

  // Byte-lane write mask covering beat k of a line.
  function automatic logic [MASK_W-1:0] beat_mask(input logic [CNT_W-1:0] k);
    beat_mask = MASK_W'({BEAT_BYTES{1'b1}}) << (BEAT_BYTES * k);
  endfunction

endpackage

// File: rtl/icache_data_ctrl_if.sv
// Bundle of the read client, fill client and SRAM port signals of the
// icache data controller; slave is the controller side.
interface icache_data_ctrl_if;
  import icache_data_ctrl_pkg::*;

  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_set;
  logic              rd_resp_valid;
  logic              rd_resp_ready;
  logic [LINE_W-1:0] rd_resp_data;

  logic              fill_valid;
  logic              fill_ready;
  logic [ADDR_W-1:0] fill_set;
  logic [BEAT_W-1:0] fill_data;
  logic              fill_done;

  logic              sram_csb;
  logic              sram_web;
  logic [MASK_W-1:0] sram_wmask;
  logic [ADDR_W-1:0] sram_addr;
  logic [LINE_W-1:0] sram_din;
  logic [LINE_W-1:0] sram_dout;

  modport slave (
    input  rd_valid, rd_set, rd_resp_ready,
    input  fill_valid, fill_set, fill_data,
    input  sram_dout,
    output rd_ready, rd_resp_valid, rd_resp_data,
    output fill_ready, fill_done,
    output sram_csb, sram_web, sram_wmask, sram_addr, sram_din
  );

  modport master (
    output rd_valid, rd_set, rd_resp_ready,
    output fill_valid, fill_set, fill_data,
    output sram_dout,
    input  rd_ready, rd_resp_valid, rd_resp_data,
    input  fill_ready, fill_done,
    input  sram_csb, sram_web, sram_wmask, sram_addr, sram_din
  );

endinterface

// File: rtl/icache_data_ctrl.sv
// Arbitrates fetch reads and 4-beat line fills onto the single-port data SRAM.
// Optional ICACHE_DATA_CTRL_SKID_EN adds a response hold register so a stalled read response no longer blocks fills.
module icache_data_ctrl
  import icache_data_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  icache_data_ctrl_if.slave bus
);

  fill_state_e       r_fstate;
  logic [CNT_W-1:0]  r_beat;
  logic [ADDR_W-1:0] r_set;
  logic              r_resp_valid;
  logic              r_fill_done;

  logic              w_stall;
  logic              w_fill_blk;
  logic              w_rd_ready;
  logic              w_fill_ready;
  logic              w_rd_fire;
  logic              w_fill_fire;
  logic [ADDR_W-1:0] w_fill_addr;
  logic [LINE_W-1:0] w_din_rep;
  logic [LINE_W-1:0] w_resp_data;

  logic              w_csb;
  logic              w_web;
  logic [MASK_W-1:0] w_wmask;
  logic [ADDR_W-1:0] w_addr;
  logic [LINE_W-1:0] w_din;

  // A pending, unaccepted response must not see the SRAM output move.
  assign w_stall = r_resp_valid && !bus.rd_resp_ready;

`ifdef ICACHE_DATA_CTRL_SKID_EN
  assign w_fill_blk = 1'b0;
`else
  assign w_fill_blk = w_stall;
`endif

  assign w_fill_ready = rst_n && !w_fill_blk;
  assign w_rd_ready   = rst_n && !w_stall && !bus.fill_valid && (r_fstate == F_IDLE);
  assign w_fill_fire  = bus.fill_valid && w_fill_ready;
  assign w_rd_fire    = bus.rd_valid && w_rd_ready;
  assign w_fill_addr  = (r_fstate == F_IDLE) ? bus.fill_set : r_set;

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_din_rep
      assign w_din_rep[gi*BEAT_W +: BEAT_W] = bus.fill_data;
    end
  endgenerate

  always_comb begin
    w_csb   = 1'b1;
    w_web   = 1'b1;
    w_wmask = '0;
    w_addr  = '0;
    w_din   = '0;
    if (w_fill_fire) begin
      w_csb   = 1'b0;
      w_web   = 1'b0;
      w_wmask = beat_mask(r_beat);
      w_addr  = w_fill_addr;
      w_din   = w_din_rep;
    end else if (w_rd_fire) begin
      w_csb   = 1'b0;
      w_addr  = bus.rd_set;
    end
  end

  // Fill FSM: set latched on beat 0, counter returns to 0 after the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fstate    <= F_IDLE;
      r_beat      <= '0;
      r_set       <= '0;
      r_fill_done <= 1'b0;
    end else begin
      r_fill_done <= 1'b0;
      case (r_fstate)
        F_IDLE: begin
          if (w_fill_fire) begin
            r_set    <= bus.fill_set;
            r_beat   <= CNT_W'(1);
            r_fstate <= F_BURST;
          end
        end
        F_BURST: begin
          if (w_fill_fire) begin
            r_beat <= r_beat + CNT_W'(1);
            if (r_beat == CNT_W'(BEATS - 1)) begin
              r_fstate    <= F_IDLE;
              r_fill_done <= 1'b1;
            end
          end
        end
        default: r_fstate <= F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
    end else if (w_rd_fire) begin
      r_resp_valid <= 1'b1;
    end else if (bus.rd_resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

`ifdef ICACHE_DATA_CTRL_SKID_EN
  logic              r_resp_first;
  logic [LINE_W-1:0] r_hold;

  // SRAM output is only trusted in the first response cycle; later cycles replay the copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_first <= 1'b0;
      r_hold       <= '0;
    end else begin
      r_resp_first <= w_rd_fire;
      if (r_resp_first) begin
        r_hold <= bus.sram_dout;
      end
    end
  end

  assign w_resp_data = r_resp_first ? bus.sram_dout : r_hold;
`else
  assign w_resp_data = bus.sram_dout;
`endif

  assign bus.rd_ready      = w_rd_ready;
  assign bus.fill_ready    = w_fill_ready;
  assign bus.rd_resp_valid = r_resp_valid;
  assign bus.rd_resp_data  = w_resp_data;
  assign bus.fill_done     = r_fill_done;
  assign bus.sram_csb      = w_csb;
  assign bus.sram_web      = w_web;
  assign bus.sram_wmask    = w_wmask;
  assign bus.sram_addr     = w_addr;
  assign bus.sram_din      = w_din;

endmodule

// File: tb/tb_icache_data_ctrl.sv
// Directed bench for icache_data_ctrl: a vector table for the basic fill/read flow,
// plus hand-written sequences for arbitration, stalls, back-to-back reads and mid-burst reset.
module tb_icache_data_ctrl;
  import icache_data_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  icache_data_ctrl_if bus();

  icache_data_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Behavioural SRAM: registered inputs, output updated only by reads.
  logic [LINE_W-1:0] mem [SETS];
  logic [LINE_W-1:0] dout_r;
  always @(posedge clk) begin
    if (!bus.sram_csb) begin
      if (!bus.sram_web) begin
        for (int b = 0; b < MASK_W; b++)
          if (bus.sram_wmask[b]) mem[bus.sram_addr][8*b +: 8] <= bus.sram_din[8*b +: 8];
      end else begin
        dout_r <= mem[bus.sram_addr];
      end
    end
  end
  assign bus.sram_dout = dout_r;

  int n_tests = 0;
  int n_fail  = 0;
  logic [255:0] ref_mem [16];

  typedef struct {
    logic         rv;
    logic [3:0]   rs;
    logic         rr;
    logic         fv;
    logic [3:0]   fs;
    logic [63:0]  fd;
    logic         e_rdy;
    logic         e_frdy;
    logic         e_csb;
    logic         e_web;
    logic [31:0]  e_wmask;
    logic [3:0]   e_addr;
    logic [255:0] e_din;
    logic         e_rvld;
    logic         e_done;
    logic         e_chk;
    logic [255:0] e_data;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_drv(input string nm, input logic csb, input logic web,
                         input logic [31:0] wm, input logic [3:0] a, input logic [255:0] din);
    chk({nm, ".csb"},   256'(bus.sram_csb),   256'(csb));
    chk({nm, ".web"},   256'(bus.sram_web),   256'(web));
    chk({nm, ".wmask"}, 256'(bus.sram_wmask), 256'(wm));
    chk({nm, ".addr"},  256'(bus.sram_addr),  256'(a));
    chk({nm, ".din"},   bus.sram_din,         din);
  endtask

  function automatic logic [255:0] line_pat(input logic [3:0] s);
    logic [255:0] l;
    for (int k = 0; k < 4; k++)
      l[64*k +: 64] = {16'hA5A5, 8'(s), 8'(k), 32'hC0DE_0000 ^ {24'h0, 4'(k), s}};
    return l;
  endfunction

  // Starts at a falling edge; issues 4 back-to-back beats, ends in the fill_done cycle.
  task automatic fill_line(input logic [3:0] s, input logic [255:0] l);
    for (int k = 0; k < 4; k++) begin
      bus.fill_valid = 1'b1;
      bus.fill_set   = (k == 0) ? s : ~s;
      bus.fill_data  = l[64*k +: 64];
      #1;
      chk($sformatf("fill%0d.b%0d.fill_ready", s, k), 256'(bus.fill_ready), 256'(1'b1));
      chk($sformatf("fill%0d.b%0d.rd_ready", s, k),   256'(bus.rd_ready),   256'(1'b0));
      chk_drv($sformatf("fill%0d.b%0d", s, k), 1'b0, 1'b0, 32'hFF << (8*k), s, {4{l[64*k +: 64]}});
      @(negedge clk);
    end
    bus.fill_valid = 1'b0;
    #1;
    chk($sformatf("fill%0d.done", s), 256'(bus.fill_done), 256'(1'b1));
    ref_mem[s] = l;
  endtask

  task automatic do_read(input logic [3:0] s);
    bus.rd_valid      = 1'b1;
    bus.rd_set        = s;
    bus.rd_resp_ready = 1'b1;
    #1;
    chk($sformatf("read%0d.rd_ready", s), 256'(bus.rd_ready), 256'(1'b1));
    chk_drv($sformatf("read%0d.issue", s), 1'b0, 1'b1, 32'h0, s, 256'h0);
    @(negedge clk);
    bus.rd_valid = 1'b0;
    #1;
    chk($sformatf("read%0d.resp_valid", s), 256'(bus.rd_resp_valid), 256'(1'b1));
    chk($sformatf("read%0d.data", s),       bus.rd_resp_data,         ref_mem[s]);
    @(negedge clk);
    #1;
    chk($sformatf("read%0d.retired", s), 256'(bus.rd_resp_valid), 256'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  b [4];
    logic [255:0] line5, l7, l9, l11, l12;
    int           seq [5];

    for (int k = 0; k < 4; k++) b[k] = {16{4'(k)}};
    line5 = {b[3], b[2], b[1], b[0]};

    // rv rs rr fv fs fd | rdy frdy csb web wmask addr din | rvld done chk data
    vt[0] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0,  64'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,        4'd0, 256'd0,       1'b0, 1'b0, 1'b0, 256'd0};
    vt[1] = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd5,  b[0],  1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00FF, 4'd5, {4{b[0]}},    1'b0, 1'b0, 1'b0, 256'd0};
    vt[2] = '{1'b0, 4'd0, 1'b1, 1'b1, 4'hA,  b[1],  1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_FF00, 4'd5, {4{b[1]}},    1'b0, 1'b0, 1'b0, 256'd0};
    vt[3] = '{1'b1, 4'd2, 1'b1, 1'b1, 4'hA,  b[2],  1'b0, 1'b1, 1'b0, 1'b0, 32'h00FF_0000, 4'd5, {4{b[2]}},    1'b0, 1'b0, 1'b0, 256'd0};
    vt[4] = '{1'b0, 4'd0, 1'b1, 1'b1, 4'hA,  b[3],  1'b0, 1'b1, 1'b0, 1'b0, 32'hFF00_0000, 4'd5, {4{b[3]}},    1'b0, 1'b0, 1'b0, 256'd0};
    vt[5] = '{1'b1, 4'd5, 1'b1, 1'b0, 4'd0,  64'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        4'd5, 256'd0,       1'b0, 1'b1, 1'b0, 256'd0};
    vt[6] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0,  64'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,        4'd0, 256'd0,       1'b1, 1'b0, 1'b1, line5};
    vt[7] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0,  64'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,        4'd0, 256'd0,       1'b0, 1'b0, 1'b0, 256'd0};

    bus.rd_valid      = 1'b1;
    bus.rd_set        = 4'd0;
    bus.rd_resp_ready = 1'b0;
    bus.fill_valid    = 1'b1;
    bus.fill_set      = 4'd0;
    bus.fill_data     = 64'd0;
    #2 rst_n = 1'b0;

    // Reset state with both clients requesting.
    @(negedge clk);
    #1;
    chk("rst.rd_ready",   256'(bus.rd_ready),      256'(1'b0));
    chk("rst.fill_ready", 256'(bus.fill_ready),    256'(1'b0));
    chk("rst.csb",        256'(bus.sram_csb),      256'(1'b1));
    chk("rst.resp_valid", 256'(bus.rd_resp_valid), 256'(1'b0));
    chk("rst.fill_done",  256'(bus.fill_done),     256'(1'b0));
    @(negedge clk);
    rst_n          = 1'b1;
    bus.rd_valid   = 1'b0;
    bus.fill_valid = 1'b0;

    // Fill set 5, read it back in the fill_done cycle.
    for (int i = 0; i < 8; i++) begin
      bus.rd_valid      = vt[i].rv;
      bus.rd_set        = vt[i].rs;
      bus.rd_resp_ready = vt[i].rr;
      bus.fill_valid    = vt[i].fv;
      bus.fill_set      = vt[i].fs;
      bus.fill_data     = vt[i].fd;
      #1;
      chk($sformatf("vec%0d.rd_ready", i),   256'(bus.rd_ready),      256'(vt[i].e_rdy));
      chk($sformatf("vec%0d.fill_ready", i), 256'(bus.fill_ready),    256'(vt[i].e_frdy));
      chk_drv($sformatf("vec%0d", i), vt[i].e_csb, vt[i].e_web, vt[i].e_wmask, vt[i].e_addr, vt[i].e_din);
      chk($sformatf("vec%0d.resp_valid", i), 256'(bus.rd_resp_valid), 256'(vt[i].e_rvld));
      chk($sformatf("vec%0d.fill_done", i),  256'(bus.fill_done),     256'(vt[i].e_done));
      if (vt[i].e_chk) chk($sformatf("vec%0d.data", i), bus.rd_resp_data, vt[i].e_data);
      @(negedge clk);
    end
    ref_mem[5] = line5;

    for (int s = 0; s < 4; s++) begin
      fill_line(4'(s), line_pat(4'(s)));
      @(negedge clk);
    end

    // Back-to-back reads of sets 0..3, one response per cycle.
    for (int i = 0; i <= 4; i++) begin
      bus.rd_resp_ready = 1'b1;
      bus.rd_valid      = (i < 4);
      bus.rd_set        = 4'(i);
      #1;
      if (i < 4) begin
        chk($sformatf("b2b%0d.rd_ready", i), 256'(bus.rd_ready),  256'(1'b1));
        chk($sformatf("b2b%0d.addr", i),     256'(bus.sram_addr), 256'(4'(i)));
        chk($sformatf("b2b%0d.csb", i),      256'(bus.sram_csb),  256'(1'b0));
      end
      if (i > 0) begin
        chk($sformatf("b2b%0d.resp_valid", i), 256'(bus.rd_resp_valid), 256'(1'b1));
        chk($sformatf("b2b%0d.data", i),       bus.rd_resp_data,         ref_mem[i-1]);
      end
      @(negedge clk);
    end
    #1;
    chk("b2b.end.resp_valid", 256'(bus.rd_resp_valid), 256'(1'b0));
    @(negedge clk);

    // Simultaneous read (set 2) and fill (set 7), with one beat gap.
    l7     = line_pat(4'd7);
    seq    = '{0, 1, -1, 2, 3};
    bus.rd_valid = 1'b1;
    bus.rd_set   = 4'd2;
    for (int j = 0; j < 5; j++) begin
      if (seq[j] < 0) begin
        bus.fill_valid = 1'b0;
        #1;
        chk("arb.gap.rd_ready",   256'(bus.rd_ready),   256'(1'b0));
        chk("arb.gap.csb",        256'(bus.sram_csb),   256'(1'b1));
        chk("arb.gap.fill_ready", 256'(bus.fill_ready), 256'(1'b1));
      end else begin
        bus.fill_valid = 1'b1;
        bus.fill_set   = (seq[j] == 0) ? 4'd7 : 4'd0;
        bus.fill_data  = l7[64*seq[j] +: 64];
        #1;
        chk($sformatf("arb.b%0d.rd_ready", seq[j]), 256'(bus.rd_ready), 256'(1'b0));
        chk_drv($sformatf("arb.b%0d", seq[j]), 1'b0, 1'b0, 32'hFF << (8*seq[j]), 4'd7, {4{l7[64*seq[j] +: 64]}});
      end
      @(negedge clk);
    end
    bus.fill_valid = 1'b0;
    #1;
    chk("arb.fill_done", 256'(bus.fill_done), 256'(1'b1));
    chk("arb.rd_ready",  256'(bus.rd_ready),  256'(1'b1));
    chk_drv("arb.rd", 1'b0, 1'b1, 32'h0, 4'd2, 256'h0);
    ref_mem[7] = l7;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    #1;
    chk("arb.resp_valid", 256'(bus.rd_resp_valid), 256'(1'b1));
    chk("arb.data",       bus.rd_resp_data,         ref_mem[2]);
    @(negedge clk);
    do_read(4'd7);
    @(negedge clk);

    // Read set 3, hold the response for 5 cycles while a fill to set 9 waits.
    l9 = line_pat(4'd9);
    bus.rd_valid      = 1'b1;
    bus.rd_set        = 4'd3;
    bus.rd_resp_ready = 1'b0;
    #1;
    chk("stall.issue.rd_ready", 256'(bus.rd_ready), 256'(1'b1));
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.rd_valid = 1'b0;
`ifdef ICACHE_DATA_CTRL_SKID_EN
      bus.fill_valid = (i < 4);
      bus.fill_set   = (i == 0) ? 4'd9 : 4'd0;
      bus.fill_data  = l9[64*(i%4) +: 64];
`else
      bus.fill_valid = 1'b1;
      bus.fill_set   = 4'd9;
      bus.fill_data  = l9[63:0];
`endif
      #1;
      chk($sformatf("stall%0d.resp_valid", i), 256'(bus.rd_resp_valid), 256'(1'b1));
      chk($sformatf("stall%0d.data", i),       bus.rd_resp_data,         ref_mem[3]);
      chk($sformatf("stall%0d.rd_ready", i),   256'(bus.rd_ready),      256'(1'b0));
`ifdef ICACHE_DATA_CTRL_SKID_EN
      chk($sformatf("stall%0d.fill_ready", i), 256'(bus.fill_ready), 256'(1'b1));
      if (i < 4) chk_drv($sformatf("stall%0d.beat", i), 1'b0, 1'b0, 32'hFF << (8*i), 4'd9, {4{l9[64*i +: 64]}});
      else       chk("stall.fill_done", 256'(bus.fill_done), 256'(1'b1));
`else
      chk($sformatf("stall%0d.fill_ready", i), 256'(bus.fill_ready), 256'(1'b0));
      chk($sformatf("stall%0d.csb", i),        256'(bus.sram_csb),   256'(1'b1));
`endif
      @(negedge clk);
    end
    bus.rd_resp_ready = 1'b1;
    #1;
    chk("stall.release.resp_valid", 256'(bus.rd_resp_valid), 256'(1'b1));
    chk("stall.release.data",       bus.rd_resp_data,         ref_mem[3]);
`ifdef ICACHE_DATA_CTRL_SKID_EN
    ref_mem[9] = l9;
`else
    fill_line(4'd9, l9);
`endif
    @(negedge clk);
    #1;
    chk("stall.retired", 256'(bus.rd_resp_valid), 256'(1'b0));
    @(negedge clk);
    do_read(4'd9);
    @(negedge clk);

    // Reset after beat 1 of a fill to set 11, then a full fill to set 12.
    l11 = line_pat(4'd11);
    l12 = line_pat(4'd12);
    for (int k = 0; k < 2; k++) begin
      bus.fill_valid = 1'b1;
      bus.fill_set   = (k == 0) ? 4'd11 : 4'd0;
      bus.fill_data  = l11[64*k +: 64];
      #1;
      chk_drv($sformatf("mid.b%0d", k), 1'b0, 1'b0, 32'hFF << (8*k), 4'd11, {4{l11[64*k +: 64]}});
      @(negedge clk);
    end
    rst_n        = 1'b0;
    bus.rd_valid = 1'b1;
    #1;
    chk("mid.rst.rd_ready",   256'(bus.rd_ready),      256'(1'b0));
    chk("mid.rst.fill_ready", 256'(bus.fill_ready),    256'(1'b0));
    chk("mid.rst.csb",        256'(bus.sram_csb),      256'(1'b1));
    chk("mid.rst.resp_valid", 256'(bus.rd_resp_valid), 256'(1'b0));
    chk("mid.rst.fill_done",  256'(bus.fill_done),     256'(1'b0));
    @(negedge clk);
    rst_n          = 1'b1;
    bus.rd_valid   = 1'b0;
    bus.fill_valid = 1'b0;
    fill_line(4'd12, l12);
    @(negedge clk);
    do_read(4'd12);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
